// File: rtl/snake_pkg.sv
// Shared grid geometry, direction/FSM encodings and the cell coordinate type
// for the snake datapath.
package snake_pkg;
  localparam int GRID_W  = 32;
  localparam int GRID_H  = 24;
  localparam int CELL_PX = 20;
  localparam int CW      = 5;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_COMMIT,
    S_DEAD
  } state_t;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } coord_t;
endpackage

// File: rtl/snake_seg_buf.sv
// Body position shift buffer with length register, indexed scan read port
// and combinational renderer hit lookup.
module snake_seg_buf
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int START_LEN = 3,
  parameter int X0        = 16,
  parameter int Y0        = 12,
  parameter int IW        = $clog2(MAX_LEN),
  parameter int LW        = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          shift,
  input  logic          grow_en,
  input  coord_t        head_in,
  input  logic [IW-1:0] rd_idx,
  output coord_t        rd_seg,
  output coord_t        head,
  output logic [LW-1:0] len,
  input  coord_t        query,
  output logic          query_hit
);
  coord_t seg [MAX_LEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++)
        seg[i] <= (i < START_LEN) ? coord_t'{x: CW'(X0 - i), y: CW'(Y0)} : '0;
      len <= LW'(START_LEN);
    end else if (shift) begin
      for (int i = 1; i < MAX_LEN; i++) seg[i] <= seg[i-1];
      seg[0] <= head_in;
      // At full depth the shift itself drops the tail
      if (grow_en && len < LW'(MAX_LEN)) len <= len + 1'b1;
    end
  end

  assign rd_seg = seg[rd_idx];
  assign head   = seg[0];

  always_comb begin
    query_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if (LW'(i) < len && seg[i] == query) query_hit = 1'b1;
  end
endmodule

// File: rtl/snake_mover.sv
// Snake move FSM: per-tick candidate head, wall check, serial self-collision
// scan, then a one-cycle body shift.
module snake_mover #(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int MAX_LEN   = 16,
  parameter int START_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [1:0] dir_req,
  input  logic       dir_valid,
  input  logic       grow,
  input  logic [4:0] query_x,
  input  logic [4:0] query_y,
  output logic       query_hit,
  output logic [4:0] head_x,
  output logic [4:0] head_y,
  output logic [4:0] length,
  output logic       moved,
  output logic       game_over
);
  import snake_pkg::*;

  localparam int IW = $clog2(MAX_LEN);
  localparam int LW = $clog2(MAX_LEN + 1);

  state_t        state;
  dir_t          dir, next_dir;
  logic          pending_grow, hit;
  coord_t        cand, cmp_seg, rd_seg, head_c;
  logic [LW-1:0] scan_idx, cmp_idx, len;
  logic [5:0]    nx, ny;
  logic          wall, live, seg_match;

  snake_seg_buf #(
    .MAX_LEN(MAX_LEN), .START_LEN(START_LEN), .X0(GRID_W / 2), .Y0(GRID_H / 2)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .shift    (state == S_COMMIT),
    .grow_en  (pending_grow | grow),
    .head_in  (cand),
    .rd_idx   (scan_idx[IW-1:0]),
    .rd_seg   (rd_seg),
    .head     (head_c),
    .len      (len),
    .query    ('{x: query_x, y: query_y}),
    .query_hit(query_hit)
  );

  // Candidate computed one bit wider so stepping off either edge is visible
  always_comb begin
    nx = {1'b0, head_c.x};
    ny = {1'b0, head_c.y};
    case (next_dir)
      DIR_UP:    ny = ny - 6'd1;
      DIR_RIGHT: nx = nx + 6'd1;
      DIR_DOWN:  ny = ny + 6'd1;
      DIR_LEFT:  nx = nx - 6'd1;
      default:   ;
    endcase
    wall = (nx >= 6'(GRID_W)) || (ny >= 6'(GRID_H));
  end

  // Read port is registered: cmp_seg holds seg[scan_idx-1]; the tail only
  // counts when it will not vacate this move
  assign cmp_idx   = scan_idx - 1'b1;
  assign live      = (cmp_idx < len - 1'b1) || (pending_grow && cmp_idx < len);
  assign seg_match = (scan_idx != '0) && live && (cmp_seg == cand);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      dir          <= DIR_RIGHT;
      next_dir     <= DIR_RIGHT;
      pending_grow <= 1'b0;
      hit          <= 1'b0;
      scan_idx     <= '0;
      cand         <= '0;
      cmp_seg      <= '0;
      moved        <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (state != S_DEAD) begin
        if (dir_valid && dir_req != (dir ^ 2'd2)) next_dir <= dir_t'(dir_req);
        if (grow) pending_grow <= 1'b1;
      end
      case (state)
        S_IDLE: if (tick) begin
          if (wall) begin
            state     <= S_DEAD;
            game_over <= 1'b1;
          end else begin
            cand     <= '{x: nx[4:0], y: ny[4:0]};
            hit      <= 1'b0;
            scan_idx <= '0;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          cmp_seg  <= rd_seg;
          scan_idx <= scan_idx + 1'b1;
          if (seg_match) hit <= 1'b1;
          if (scan_idx == LW'(MAX_LEN)) begin
            if (hit || seg_match) begin
              state     <= S_DEAD;
              game_over <= 1'b1;
            end else begin
              state <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          dir          <= next_dir;
          pending_grow <= 1'b0;
          moved        <= 1'b1;
          state        <= S_IDLE;
        end
        S_DEAD: game_over <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign head_x = head_c.x;
  assign head_y = head_c.y;
  assign length = 5'(len);
endmodule

// File: tb/tb_snake_mover.sv
// Directed + randomized bench for snake_mover against a queue-based game model.
module tb_snake_mover;
  localparam int MAX_LEN   = 16;
  localparam int START_LEN = 3;
  localparam int GW = 32, GH = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, dir_valid = 1'b0, grow = 1'b0;
  logic [1:0] dir_req = 2'd0;
  logic [4:0] query_x = '0, query_y = '0;
  logic       query_hit, moved, game_over;
  logic [4:0] head_x, head_y, length;

  snake_mover #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(MAX_LEN), .START_LEN(START_LEN)) u_dut (
    .clk(clk), .rst(rst), .tick(tick), .dir_req(dir_req), .dir_valid(dir_valid),
    .grow(grow), .query_x(query_x), .query_y(query_y), .query_hit(query_hit),
    .head_x(head_x), .head_y(head_y), .length(length), .moved(moved),
    .game_over(game_over)
  );

  always #10 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Game model: body as head-first coordinate lists
  int mx[$], my[$];
  int mlen, mdir, mnext;
  bit mpend, mdead;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = {};
    my = {};
    for (int i = 0; i < START_LEN; i++) begin
      mx.push_back(GW / 2 - i);
      my.push_back(GH / 2);
    end
    mlen = START_LEN; mdir = 1; mnext = 1; mpend = 0; mdead = 0;
  endtask

  function automatic bit model_hit(int x, int y, int n);
    for (int i = 0; i < n; i++)
      if (mx[i] == x && my[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_tick();
    int cx, cy, n;
    if (mdead) return 1'b0;
    cx = mx[0] + (mnext == 1 ? 1 : 0) - (mnext == 3 ? 1 : 0);
    cy = my[0] + (mnext == 2 ? 1 : 0) - (mnext == 0 ? 1 : 0);
    if (cx < 0 || cx >= GW || cy < 0 || cy >= GH) begin
      mdead = 1; return 1'b0;
    end
    n = mpend ? mlen : mlen - 1;
    if (model_hit(cx, cy, n)) begin
      mdead = 1; return 1'b0;
    end
    mx.push_front(cx);
    my.push_front(cy);
    if (mpend && mlen < MAX_LEN) mlen++;
    while (mx.size() > mlen) begin
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    mdir = mnext;
    mpend = 0;
    return 1'b1;
  endfunction

  task automatic query_chk(input string tag, input int x, input int y, input bit exp);
    @(negedge clk);
    query_x = 5'(x);
    query_y = 5'(y);
    #1;
    chk(tag, query_hit, exp);
  endtask

  task automatic check_state(input string tag);
    int rx, ry;
    chk({tag, ".head_x"}, head_x, mx[0]);
    chk({tag, ".head_y"}, head_y, my[0]);
    chk({tag, ".length"}, length, mlen);
    chk({tag, ".game_over"}, game_over, mdead);
    for (int i = 0; i < mlen; i++) query_chk({tag, ".seg_hit"}, mx[i], my[i], 1'b1);
    rx = $urandom_range(0, GW - 1);
    ry = $urandom_range(0, GH - 1);
    query_chk({tag, ".rand_hit"}, rx, ry, model_hit(rx, ry, mlen));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    chk({tag, ".moved"}, moved, 1'b0);
    check_state(tag);
  endtask

  task automatic req_dir(input int d);
    @(negedge clk); dir_valid = 1'b1; dir_req = 2'(d);
    @(negedge clk); dir_valid = 1'b0;
    if (!mdead && d != (mdir ^ 2)) mnext = d;
  endtask

  task automatic grow_pulse();
    @(negedge clk); grow = 1'b1;
    @(negedge clk); grow = 1'b0;
    if (!mdead) mpend = 1;
  endtask

  // Tick, optionally re-tick mid-scan, and watch the full move window
  task automatic do_tick(input string tag, input bit extra);
    bit exp_mv;
    int mvcnt = 0;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    exp_mv = model_tick();
    for (int i = 1; i <= MAX_LEN + 3; i++) begin
      @(negedge clk);
      tick = extra && (i == 4);
      if (moved === 1'b1) mvcnt++;
      if (i == MAX_LEN + 1) chk({tag, ".moved_early"}, moved, 1'b0);
      if (i == MAX_LEN + 2) chk({tag, ".moved_latency"}, moved, exp_mv);
    end
    tick = 1'b0;
    chk({tag, ".moved_count"}, mvcnt, exp_mv);
    check_state(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    do_reset("reset");
    query_chk("reset.off_body", 13, 12, 1'b0);

    do_tick("tick_plain", 1'b0);
    query_chk("tick_plain.old_tail", 14, 12, 1'b0);
    req_dir(3);
    do_tick("reverse_ignored", 1'b0);
    req_dir(0);
    do_tick("turn_up", 1'b0);
    grow_pulse();
    do_tick("grow_one", 1'b1);

    // Saturation: climb up then right while growing every move
    do_reset("sat_reset");
    req_dir(0);
    for (int t = 0; t < 11; t++) begin
      grow_pulse();
      do_tick("sat_up", 1'b0);
    end
    req_dir(1);
    for (int t = 0; t < 4; t++) begin
      grow_pulse();
      do_tick("sat_right", 1'b0);
    end
    chk("sat.length_max", length, MAX_LEN);

    // Wall on the right edge
    do_reset("wall_reset");
    for (int t = 0; t < 16; t++) do_tick("wall_run", 1'b0);
    chk("wall.dead", game_over, 1'b1);
    chk("wall.head_x", head_x, 31);
    do_reset("reset_from_dead");

    // Self collision: grow to 5 then down, left, up
    grow_pulse(); do_tick("self_g1", 1'b0);
    grow_pulse(); do_tick("self_g2", 1'b0);
    req_dir(2); do_tick("self_down", 1'b0);
    req_dir(3); do_tick("self_left", 1'b0);
    req_dir(0); do_tick("self_up", 1'b0);
    chk("self.dead", game_over, 1'b1);
    grow_pulse(); req_dir(1); do_tick("dead_frozen", 1'b1);

    // Reset while the collision scan is running
    do_reset("pre_check_reset");
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    repeat (5) @(negedge clk);
    do_reset("reset_in_check");
    begin
      int mv = 0;
      for (int i = 0; i < MAX_LEN + 4; i++) begin
        @(negedge clk);
        if (moved === 1'b1) mv++;
      end
      chk("reset_in_check.no_move", mv, 0);
    end
    check_state("reset_in_check.after");

    // Random games
    for (int g = 0; g < 6; g++) begin
      do_reset("rand_reset");
      for (int t = 0; t < 30 && !mdead; t++) begin
        if ($urandom_range(0, 1) == 1) req_dir(int'($urandom_range(0, 3)));
        if ($urandom_range(0, 2) == 0) grow_pulse();
        do_tick("rand", $urandom_range(0, 3) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
